i2c_rx_sequencer: RTL and testbench
===================================

# i2c_rx_sequencer

Receive-side sequencer for the I2C listener path. Synchronises raw SCL/SDA and detects START, STOP and SCL rising edges. Drives the `en`/`clr` controls of an internal 9-bit `right_shiftreg` (8 data bits + ACK/NAK), counts bits and publishes each completed byte with a one-cycle valid strobe. Sits between the pad inputs and the protocol/register layer.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops on SCL and SDA (legal 2–3).
- `clk` in 1: system clock, all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `scl` in 1: raw bus clock, asynchronous to `clk`.
- `sda` in 1: raw bus data, asynchronous to `clk`.
- `enable` in 1: listener enable; low forces IDLE at the next edge.
- `data` out 8: last completed byte, MSB = first bit received.
- `nak` out 1: 9th bit of last completed byte (1 = NAK).
- `frame_valid` out 1: one-cycle pulse; `data`/`nak` are new this cycle.
- `start_det` out 1: one-cycle pulse on START or repeated START.
- `stop_det` out 1: one-cycle pulse on STOP.
- `abort` out 1: one-cycle pulse when a byte in progress is cut by START/STOP/`enable` low.
- `busy` out 1: high in RECV and DONE.

## Operation
- `scl_s`/`sda_s` are the last synchroniser stages; `scl_p`/`sda_p` are one further register.
- Events, per cycle:
  - `rise` = `!scl_p & scl_s`.
  - `start` = `scl_p & scl_s & sda_p & !sda_s`.
  - `stop` = `scl_p & scl_s & !sda_p & sda_s`.
  - `rise` and `start`/`stop` are mutually exclusive by construction.
- States: IDLE, RECV, DONE; `bit_cnt` is 4 bits, 0..9.
- IDLE: shift reg `clr`=1, `bit_cnt`=0. On `start` & `enable` → RECV.
- RECV: `en`=`rise`; each `rise` increments `bit_cnt`. A `rise` with `bit_cnt`==8 (9th bit) → DONE.
  - `start` → `abort` if `bit_cnt`≠0; `clr`=1, `bit_cnt`=0, stay RECV.
  - `stop` → `abort` if `bit_cnt`≠0; → IDLE.
  - `!enable` → `abort` if `bit_cnt`≠0; → IDLE.
- DONE, exactly one cycle:
  - Load `data[7-i]` ← `sr[i]` for i=0..7 and `nak` ← `sr[8]`.
  - Assert `clr`, set `bit_cnt`=0.
  - Next state: RECV by default, IDLE on `stop` or `!enable`, RECV on `start`.
  - The byte is never aborted once DONE is entered.
- `start_det`/`stop_det` pulse for every detected event while `enable`=1, in any state.
- `data`/`nak` hold their value until the next DONE load.
- There is no back-pressure: each `frame_valid` is a single-cycle pulse and the consumer must capture it.

## Timing
- Reset values: state IDLE, `bit_cnt` 0, `data` 0x00, `nak` 0, all pulses 0, `busy` 0, synchronisers all 1 (bus idle).
- IDLE holds `clr` high, so the shift register is cleared within one cycle of reset release.
- Pin-to-event latency: SYNC_STAGES+1 cycles.
- With `rise` (9th bit) at cycle T: shift commits at end of T, DONE at T+1, `frame_valid`/`data`/`nak` valid at T+2.
- Event pulses (`start_det`, `stop_det`, `abort`) are registered and appear one cycle after the event cycle.
- The 9th `rise` followed immediately by `stop` in DONE gives both `frame_valid` and `stop_det`, with no `abort`.
- Reset asserted mid-byte: all state clears immediately and no `frame_valid` is issued.
- Minimum SCL high/low time: SYNC_STAGES+2 `clk` cycles.

## Structure
- Shared package: state encoding typedef (IDLE/RECV/DONE), `FRAME_BITS`=9, `DATA_BITS`=8.
- One sub-module: `right_shiftreg` with DEPTH=`FRAME_BITS`, instantiated inside and fed `in`=`sda_s`.
- The synchroniser is inline flops; it is not a separate module.

## Test plan
- START, byte 0xA5, ACK(0), STOP → `start_det`; then `frame_valid` with `data`=0xA5, `nak`=0; then `stop_det`; `abort` never pulses.
- START, 0x3C+NAK(1), 0xFF+ACK, STOP → two `frame_valid` pulses: (0x3C,1) then (0xFF,0); no gap state between bytes.
- START, 4 bits of 0xF0, repeated START, 0x81+ACK → `abort` and `start_det` pulse together; next `frame_valid` has `data`=0x81.
- START, 5 bits, STOP → `abort` and `stop_det`, no `frame_valid`, `busy` drops; `data` retains the previous value.
- `enable`=0 during a full transaction → no pulses of any kind; set `enable`=1 mid-byte, then START, 0x5A → `data`=0x5A.
- Assert `rst_n` low after 6 bits, release, START, 0x12+ACK → all outputs are 0 during reset; then `frame_valid` with 0x12, with no residue from the cut byte.

Source files
------------

// File: rtl/i2c_rx_sequencer_pkg.sv
// Shared types and constants for the I2C receive sequencer.
// Holds the FSM state encoding, the frame geometry and the helper that turns a captured frame into a data byte.
package i2c_rx_sequencer_pkg;

   localparam int FRAME_BITS = 9;
   localparam int DATA_BITS  = 8;

   localparam logic [3:0] LAST_BIT_CNT = 4'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_DONE
   } state_t;

   // The first bit received sits in sr[0] and is the byte's MSB.
   function automatic logic [DATA_BITS-1:0] frame_to_data(input logic [FRAME_BITS-1:0] sr);
      logic [DATA_BITS-1:0] d;
      for (int i = 0; i < DATA_BITS; i++) begin
         d[DATA_BITS-1-i] = sr[i];
      end
      return d;
   endfunction

endpackage

// File: rtl/right_shiftreg.sv
// Right-shifting capture register.
// New bits enter at the MSB, so the oldest bit ends up in bit 0. A clear takes priority over a shift.
module right_shiftreg #(
   parameter int DEPTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             in,
   output logic [DEPTH-1:0] q
);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= {in, q[DEPTH-1:1]};
      end
   end

endmodule

// File: rtl/i2c_rx_sequencer.sv
// Receive-side I2C sequencer.
// Synchronises SCL/SDA, detects START/STOP/SCL-rise, and assembles 9-bit frames into data+ACK bytes.
module i2c_rx_sequencer
   import i2c_rx_sequencer_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 scl,
   input  logic                 sda,
   input  logic                 enable,
   output logic [DATA_BITS-1:0] data,
   output logic                 nak,
   output logic                 frame_valid,
   output logic                 start_det,
   output logic                 stop_det,
   output logic                 abort,
   output logic                 busy
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_p;
   logic                   r_sda_p;
   state_t                 r_state;
   logic [3:0]             r_bit_cnt;
   logic [DATA_BITS-1:0]   r_data;
   logic                   r_nak;
   logic                   r_frame_valid;
   logic                   r_start_det;
   logic                   r_stop_det;
   logic                   r_abort;

   logic                   w_scl_s;
   logic                   w_sda_s;
   logic                   w_rise;
   logic                   w_start;
   logic                   w_stop;
   state_t                 w_state_nxt;
   logic [3:0]             w_bit_cnt_nxt;
   logic                   w_sr_en;
   logic                   w_sr_clr;
   logic                   w_abort;
   logic                   w_load;
   logic [FRAME_BITS-1:0]  w_sr;

   assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
   assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

   assign w_rise  = !r_scl_p & w_scl_s;
   assign w_start = r_scl_p & w_scl_s & r_sda_p & !w_sda_s;
   assign w_stop  = r_scl_p & w_scl_s & !r_sda_p & w_sda_s;

   right_shiftreg #(
      .DEPTH(FRAME_BITS)
   ) u_shiftreg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (w_sr_en),
      .clr  (w_sr_clr),
      .in   (w_sda_s),
      .q    (w_sr)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_sr_en       = 1'b0;
      w_sr_clr      = 1'b0;
      w_abort       = 1'b0;
      w_load        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_sr_clr      = 1'b1;
            w_bit_cnt_nxt = '0;
            if (w_start && enable) w_state_nxt = ST_RECV;
         end
         ST_RECV: begin
            if (!enable || w_stop) begin
               w_abort       = (r_bit_cnt != '0);
               w_bit_cnt_nxt = '0;
               w_state_nxt   = ST_IDLE;
            end else if (w_start) begin
               w_abort       = (r_bit_cnt != '0);
               w_sr_clr      = 1'b1;
               w_bit_cnt_nxt = '0;
            end else if (w_rise) begin
               w_sr_en       = 1'b1;
               w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               if (r_bit_cnt == LAST_BIT_CNT) w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            // A completed byte is always published, whatever the bus does now.
            w_load        = 1'b1;
            w_sr_clr      = 1'b1;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (!enable || w_stop) ? ST_IDLE : ST_RECV;
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
         end
      endcase
   end

   // Synchronisers reset to 1 so an idle bus produces no spurious events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync    <= '1;
         r_sda_sync    <= '1;
         r_scl_p       <= 1'b1;
         r_sda_p       <= 1'b1;
         r_state       <= ST_IDLE;
         r_bit_cnt     <= '0;
         r_data        <= '0;
         r_nak         <= 1'b0;
         r_frame_valid <= 1'b0;
         r_start_det   <= 1'b0;
         r_stop_det    <= 1'b0;
         r_abort       <= 1'b0;
      end else begin
         r_scl_sync    <= {r_scl_sync[SYNC_STAGES-2:0], scl};
         r_sda_sync    <= {r_sda_sync[SYNC_STAGES-2:0], sda};
         r_scl_p       <= w_scl_s;
         r_sda_p       <= w_sda_s;
         r_state       <= w_state_nxt;
         r_bit_cnt     <= w_bit_cnt_nxt;
         r_frame_valid <= w_load;
         r_start_det   <= w_start & enable;
         r_stop_det    <= w_stop & enable;
         r_abort       <= w_abort;
         if (w_load) begin
            r_data <= frame_to_data(w_sr);
            r_nak  <= w_sr[FRAME_BITS-1];
         end
      end
   end

   assign data        = r_data;
   assign nak         = r_nak;
   assign frame_valid = r_frame_valid;
   assign start_det   = r_start_det;
   assign stop_det    = r_stop_det;
   assign abort       = r_abort;
   assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_i2c_rx_sequencer.sv
// Scoreboard bench for i2c_rx_sequencer: stimulus pushes expected events, a monitor pops them on each output pulse.
module tb_i2c_rx_sequencer;

   localparam int H = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda = 1'b1;
   logic       enable = 1'b1;
   logic [7:0] data;
   logic       nak;
   logic       frame_valid;
   logic       start_det;
   logic       stop_det;
   logic       abort;
   logic       busy;

   typedef enum int {EV_ABORT, EV_START, EV_FRAME, EV_STOP} ev_kind_e;
   typedef struct {
      ev_kind_e   kind;
      logic [7:0] data;
      logic       nak;
   } ev_t;

   ev_t exp_q[$];
   int  n_vec  = 0;
   int  n_miss = 0;

   always #5 clk = ~clk;

   i2c_rx_sequencer #(
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl        (scl),
      .sda        (sda),
      .enable     (enable),
      .data       (data),
      .nak        (nak),
      .frame_valid(frame_valid),
      .start_det  (start_det),
      .stop_det   (stop_det),
      .abort      (abort),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input ev_kind_e k, input logic [7:0] d = 8'h00, input logic n = 1'b0);
      ev_t e;
      e.kind = k;
      e.data = d;
      e.nak  = n;
      exp_q.push_back(e);
   endtask

   task automatic observe(input ev_kind_e k);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL unexpected pulse: got %s, expected none", k.name());
      end else begin
         e = exp_q.pop_front();
         check("event kind", 32'(k), 32'(e.kind));
         if (k == EV_FRAME && e.kind == EV_FRAME) begin
            check("frame data", 32'(data), 32'(e.data));
            check("frame nak", 32'(nak), 32'(e.nak));
         end
      end
   endtask

   // Same-cycle pulses are consumed in a fixed order: abort, start, frame, stop.
   always @(negedge clk) begin
      if (rst_n) begin
         if (abort)       observe(EV_ABORT);
         if (start_det)   observe(EV_START);
         if (frame_valid) observe(EV_FRAME);
         if (stop_det)    observe(EV_STOP);
      end
   end

   task automatic wait_h();
      repeat (H) @(negedge clk);
   endtask

   task automatic bus_start();
      scl = 1'b0; wait_h();
      sda = 1'b1; wait_h();
      scl = 1'b1; wait_h();
      sda = 1'b0; wait_h();
   endtask

   task automatic send_bit(input logic b);
      scl = 1'b0; wait_h();
      sda = b;    wait_h();
      scl = 1'b1; wait_h();
   endtask

   task automatic send_byte(input logic [7:0] d, input logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      send_bit(ack);
   endtask

   task automatic bus_stop();
      if (sda) begin
         scl = 1'b0; wait_h();
         sda = 1'b0; wait_h();
         scl = 1'b1; wait_h();
      end
      sda = 1'b1; wait_h();
   endtask

   task automatic summary();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
   endtask

   initial begin
      #1_000_000;
      n_miss++;
      $display("FAIL watchdog: simulation time limit reached");
      summary();
      $finish;
   end

   initial begin
      logic [7:0] bits5;
      logic [7:0] bits6;
      repeat (3) @(negedge clk);
      check("reset outputs", 32'({data, nak, frame_valid, start_det, stop_det, abort, busy}), 32'h0);
      rst_n = 1'b1;
      wait_h();

      // Single byte with ACK, clean stop.
      expect_ev(EV_START);
      expect_ev(EV_FRAME, 8'hA5, 1'b0);
      expect_ev(EV_STOP);
      bus_start();
      send_byte(8'hA5, 1'b0);
      bus_stop();
      check("idle after stop", 32'(busy), 32'h0);
      check("data held 0xA5", 32'(data), 32'hA5);

      // STOP one cycle after the 9th rise lands in DONE: frame and stop together, no abort.
      expect_ev(EV_START);
      expect_ev(EV_FRAME, 8'hC3, 1'b0);
      expect_ev(EV_STOP);
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(bits_c3(i));
      scl = 1'b0; wait_h();
      sda = 1'b0; wait_h();
      scl = 1'b1; @(negedge clk);
      sda = 1'b1; wait_h();

      // Back-to-back bytes, NAK then ACK.
      expect_ev(EV_START);
      expect_ev(EV_FRAME, 8'h3C, 1'b1);
      expect_ev(EV_FRAME, 8'hFF, 1'b0);
      expect_ev(EV_STOP);
      bus_start();
      send_byte(8'h3C, 1'b1);
      check("busy between bytes", 32'(busy), 32'h1);
      send_byte(8'hFF, 1'b0);
      bus_stop();

      // Repeated START cuts a partial byte.
      expect_ev(EV_START);
      expect_ev(EV_ABORT);
      expect_ev(EV_START);
      expect_ev(EV_FRAME, 8'h81, 1'b0);
      expect_ev(EV_STOP);
      bus_start();
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      bus_start();
      send_byte(8'h81, 1'b0);
      bus_stop();

      // STOP cuts a partial byte; previous byte is retained.
      expect_ev(EV_START);
      expect_ev(EV_ABORT);
      expect_ev(EV_STOP);
      bits5 = 8'b10110;
      bus_start();
      for (int i = 4; i >= 0; i--) send_bit(bits5[i]);
      bus_stop();
      check("idle after abort", 32'(busy), 32'h0);
      check("data retained 0x81", 32'(data), 32'h81);
      check("nak retained", 32'(nak), 32'h0);

      // Disabled listener ignores a full transaction, then is enabled mid-byte.
      enable = 1'b0;
      bus_start();
      send_byte(8'h77, 1'b0);
      bus_stop();
      check("disabled stays idle", 32'(busy), 32'h0);
      expect_ev(EV_START);
      expect_ev(EV_FRAME, 8'h5A, 1'b0);
      expect_ev(EV_STOP);
      bus_start();
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      enable = 1'b1;
      send_bit(1'b1);
      send_bit(1'b0);
      check("enabled mid-byte stays idle", 32'(busy), 32'h0);
      bus_start();
      send_byte(8'h5A, 1'b0);
      bus_stop();
      check("data 0x5A", 32'(data), 32'h5A);

      // Reset mid-byte, then a clean byte.
      expect_ev(EV_START);
      bits6 = 8'b101101;
      bus_start();
      for (int i = 5; i >= 0; i--) send_bit(bits6[i]);
      scl = 1'b0; wait_h();
      rst_n = 1'b0;
      @(negedge clk);
      check("outputs in reset", 32'({data, nak, frame_valid, start_det, stop_det, abort, busy}), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_h();
      expect_ev(EV_START);
      expect_ev(EV_FRAME, 8'h12, 1'b0);
      expect_ev(EV_STOP);
      bus_start();
      send_byte(8'h12, 1'b0);
      bus_stop();
      check("data 0x12 after reset", 32'(data), 32'h12);

      repeat (20) @(negedge clk);
      check("pending expected events", 32'(exp_q.size()), 32'h0);
      summary();
      $finish;
   end

   function automatic logic bits_c3(input int i);
      logic [7:0] v;
      v = 8'hC3;
      return v[i];
   endfunction

endmodule
